axi4_arbiter_rd: RTL and testbench
==================================

// Module: axi4_arbiter_rd
// PURPOSE
// - Read-direction counterpart of the AXI4 write arbiter: shares one AXI4 read master port (AR+R) between two
//   requesters (s0 = I-fetch, s1 = D-cache/uncached). Round-robin grant, bus locked per burst until RLAST handshake.
// - Sits in the fabric between the cores' read ports and the SoC AXI4 interconnect; one outstanding read total.
// PARAMETERS
// - AW  32  address width
// - DW  64  data width
// - IW   4  AXI ID width (IDs pass through unchanged; no ID remapping)
// PORTS
// - clk             in   1      clock
// - rst             in   1      asynchronous, active-high reset
// - sN_ARVALID      in   1      requester N (N=0,1) read-address valid
// - sN_ARREADY      out  1      requester N read-address ready
// - sN_ARADDR/ARID  in   AW/IW  address / ID
// - sN_ARLEN/SIZE/BURST/PROT in 8/3/2/3 burst attributes
// - sN_RVALID       out  1      read data valid to requester N
// - sN_RREADY       in   1      requester N accepts read data
// - sN_RDATA/RID    out  DW/IW  read data / ID
// - sN_RRESP/RLAST  out  2/1    response / last beat
// - m_AR*           out  -      muxed AR channel (VALID, ADDR, ID, LEN, SIZE, BURST, PROT), m_ARREADY in
// - m_R*            in   -      R channel from slave (VALID, DATA, ID, RESP, LAST), m_RREADY out
// - m_RGRNT         out  2      one-hot grant {s1,s0}; 2'b00 when idle
// BEHAVIOUR
// - FSM states: IDLE, ADDR, DATA. Registers: state, gnt[1:0] (one-hot), prio (0 = s0 preferred).
// - Reset (async): state=IDLE, gnt=0, prio=0; all sN_ARREADY, sN_RVALID, m_ARVALID, m_RREADY = 0.
// - IDLE: sample s0/s1_ARVALID. Only one valid -> grant it. Both -> grant prio side. None -> stay.
//   Grant registered: m_ARVALID rises the cycle after ARVALID seen in IDLE (1-cycle arbitration latency).
// - ADDR: m_AR* = granted sN_AR*; m_ARVALID = granted sN_ARVALID; granted sN_ARREADY = m_ARREADY.
//   m_ARVALID&m_ARREADY -> DATA. Granted requester dropping ARVALID (protocol error): stay in ADDR, no timeout.
// - DATA: granted sN_RVALID = m_RVALID, sN_R* = m_R*, m_RREADY = granted sN_RREADY (combinational, 0 added latency).
//   m_RVALID&m_RREADY&m_RLAST -> IDLE, gnt=0, prio = other requester (toggle on completion only).
// - Non-granted requester: ARREADY=0, RVALID=0 always; its RDATA etc. may reflect m_R* (don't care).
// - Outside ADDR: m_ARVALID=0. Outside DATA: m_RREADY=0, all sN_RVALID=0. m_AR* payload don't-care when not valid.
// - Stray m_RVALID in IDLE/ADDR: not acknowledged (m_RREADY=0); flag via simulation assertion.
// - Back-to-back: RLAST handshake and pending ARVALID in same cycle -> IDLE next cycle, new AR issued the cycle
//   after (2-cycle minimum gap between last R beat and next m_ARVALID).
// - RRESP SLVERR/DECERR passed through unmodified; burst still terminates only on RLAST.
// - ARLEN=0 (single beat): first beat carries RLAST; same DATA->IDLE exit.
// - Reset mid-burst: immediate return to reset values; in-flight burst abandoned (interconnect reset together).
// STRUCTURE
// - Shared fabric package: AXI4 width constants (LEN/SIZE/BURST/PROT/RESP widths), RESP codes, arbiter state
//   encodings (also reused by the write arbiter for consistency).
// - One sub-module: axi4_rr_pick2 (2-way round-robin picker: req[1:0], prio -> one-hot grant, combinational).
// - Datapath is pure muxing on registered gnt; no payload buffering.
// TESTING
// - Reset: hold rst, drive random inputs -> all outputs 0, m_RGRNT=00; release -> IDLE.
// - Single s1 read, ARLEN=3: s1_ARVALID at t0 -> m_ARVALID at t1 with s1 ADDR/ID; 4 beats to s1, s0_RVALID=0 throughout.
// - Contention, prio=0: s0,s1 ARVALID same cycle -> s0 served, after s0 RLAST s1 granted; then both again -> s0 (fairness).
// - Backpressure: m_ARREADY low 5 cycles, s0_RREADY toggling -> ARADDR stable, no beat lost/duplicated, m_RREADY==s0_RREADY.
// - ARLEN=0 with RRESP=SLVERR -> one beat, RLAST=1, RRESP=2'b10 at requester, return to IDLE.
// - Async reset asserted on beat 2 of 8 -> outputs 0 same cycle, grant cleared, next request arbitrated with prio=0.

Source files
------------

// File: rtl/axi4_arbiter_rd_pkg.sv
// rtl/axi4_arbiter_rd_pkg.sv - shared AXI4 fabric widths, response codes and arbiter state encodings
package axi4_arbiter_rd_pkg;

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned BURST_W = 2;
    localparam int unsigned PROT_W  = 3;
    localparam int unsigned RESP_W  = 2;

    typedef enum logic [RESP_W-1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    // Shared with the write arbiter so both directions decode identically in waveforms.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

endpackage

// File: rtl/axi4_arbiter_rd_if.sv
// rtl/axi4_arbiter_rd_if.sv - AXI4 read port bundle (AR + R channels)
interface axi4_arbiter_rd_if
    import axi4_arbiter_rd_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 64,
    parameter int unsigned IW = 4
);
    logic               arvalid;
    logic               arready;
    logic [AW-1:0]      araddr;
    logic [IW-1:0]      arid;
    logic [LEN_W-1:0]   arlen;
    logic [SIZE_W-1:0]  arsize;
    logic [BURST_W-1:0] arburst;
    logic [PROT_W-1:0]  arprot;
    logic               rvalid;
    logic               rready;
    logic [DW-1:0]      rdata;
    logic [IW-1:0]      rid;
    logic [RESP_W-1:0]  rresp;
    logic               rlast;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, arprot, rready,
        input  arready, rvalid, rdata, rid, rresp, rlast
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, arprot, rready,
        output arready, rvalid, rdata, rid, rresp, rlast
    );
endinterface

// File: rtl/axi4_rr_pick2.sv
// rtl/axi4_rr_pick2.sv - two-way round-robin picker, one-hot grant, combinational
module axi4_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);
    always_comb begin
        gnt_o = req_i;
        if (&req_i) begin
            gnt_o = prio_i ? 2'b10 : 2'b01;
        end
    end
endmodule

// File: rtl/axi4_arbiter_rd.sv
// rtl/axi4_arbiter_rd.sv - shares one AXI4 read master between two requesters, bus locked per burst
module axi4_arbiter_rd
    import axi4_arbiter_rd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    axi4_arbiter_rd_if.slave  s0,
    axi4_arbiter_rd_if.slave  s1,
    axi4_arbiter_rd_if.master m,
    output logic [1:0]        m_rgrnt_o
);
    arb_state_e state_q;
    logic [1:0] gnt_q;
    logic       prio_q;
    logic [1:0] pick;
    logic       sel_s1;
    logic       in_addr;
    logic       in_data;
    logic       ar_hs;
    logic       r_last_hs;

    axi4_rr_pick2 u_pick (
        .req_i  ({s1.arvalid, s0.arvalid}),
        .prio_i (prio_q),
        .gnt_o  (pick)
    );

    assign sel_s1    = gnt_q[1];
    assign in_addr   = (state_q == ST_ADDR);
    assign in_data   = (state_q == ST_DATA);
    assign ar_hs     = m.arvalid & m.arready;
    assign r_last_hs = m.rvalid & m.rready & m.rlast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            prio_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pick) begin
                        gnt_q   <= pick;
                        state_q <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (ar_hs) begin
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Priority moves only when a burst completes, towards the requester not just served.
                    if (r_last_hs) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= 2'b00;
                        prio_q  <= gnt_q[0];
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    assign m_rgrnt_o = gnt_q;

    assign m.arvalid = in_addr & (sel_s1 ? s1.arvalid : s0.arvalid);
    assign m.araddr  = sel_s1 ? s1.araddr  : s0.araddr;
    assign m.arid    = sel_s1 ? s1.arid    : s0.arid;
    assign m.arlen   = sel_s1 ? s1.arlen   : s0.arlen;
    assign m.arsize  = sel_s1 ? s1.arsize  : s0.arsize;
    assign m.arburst = sel_s1 ? s1.arburst : s0.arburst;
    assign m.arprot  = sel_s1 ? s1.arprot  : s0.arprot;
    assign m.rready  = in_data & (sel_s1 ? s1.rready : s0.rready);

    assign s0.arready = in_addr & gnt_q[0] & m.arready;
    assign s1.arready = in_addr & gnt_q[1] & m.arready;

    // R payload is broadcast; only the granted side ever sees RVALID.
    assign s0.rvalid = in_data & gnt_q[0] & m.rvalid;
    assign s1.rvalid = in_data & gnt_q[1] & m.rvalid;
    assign s0.rdata  = m.rdata;
    assign s1.rdata  = m.rdata;
    assign s0.rid    = m.rid;
    assign s1.rid    = m.rid;
    assign s0.rresp  = m.rresp;
    assign s1.rresp  = m.rresp;
    assign s0.rlast  = m.rlast;
    assign s1.rlast  = m.rlast;

    a_no_stray_rvalid : assert property (@(posedge clk) disable iff (rst)
        !(m.rvalid && (state_q != ST_DATA)))
        else $error("axi4_arbiter_rd: RVALID from slave with no burst in flight");

endmodule

// File: tb/tb_axi4_arbiter_rd.sv
// tb/tb_axi4_arbiter_rd.sv - directed, table-driven bench for axi4_arbiter_rd
module tb_axi4_arbiter_rd;
    import axi4_arbiter_rd_pkg::*;

    localparam logic [31:0] S0_ADDR = 32'h1000_0000;
    localparam logic [31:0] S1_ADDR = 32'h2000_0040;
    localparam logic [3:0]  S0_ID   = 4'h3;
    localparam logic [3:0]  S1_ID   = 4'hA;
    localparam int          NVEC    = 17;

    logic       clk;
    logic       rst;
    logic [1:0] m_rgrnt;
    int         tests;
    int         fails;

    axi4_arbiter_rd_if #(.AW(32), .DW(64), .IW(4)) s0_if ();
    axi4_arbiter_rd_if #(.AW(32), .DW(64), .IW(4)) s1_if ();
    axi4_arbiter_rd_if #(.AW(32), .DW(64), .IW(4)) m_if ();

    axi4_arbiter_rd dut (
        .clk       (clk),
        .rst       (rst),
        .s0        (s0_if),
        .s1        (s1_if),
        .m         (m_if),
        .m_rgrnt_o (m_rgrnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs: s0v s1v arrdy rv rl s0rr s1rr; expected: mav g s0ar s1ar s0rv s1rv mrr
    typedef struct packed {
        logic       s0v, s1v, arrdy, rv, rl, s0rr, s1rr;
        logic       mav;
        logic [1:0] g;
        logic       s0ar, s1ar, s0rv, s1rv, mrr;
    } vec_t;

    vec_t tbl [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        s0_if.arvalid = 1'b0;
        s1_if.arvalid = 1'b0;
        s0_if.rready  = 1'b0;
        s1_if.rready  = 1'b0;
        m_if.arready  = 1'b0;
        m_if.rvalid   = 1'b0;
        m_if.rlast    = 1'b0;
        m_if.rresp    = RESP_OKAY;
        m_if.rdata    = 64'h0;
        m_if.rid      = 4'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_arvalid"}, 64'(m_if.arvalid), 64'd0);
        check({tag, "_m_rready"},  64'(m_if.rready),  64'd0);
        check({tag, "_s0_arready"}, 64'(s0_if.arready), 64'd0);
        check({tag, "_s1_arready"}, 64'(s1_if.arready), 64'd0);
        check({tag, "_s0_rvalid"}, 64'(s0_if.rvalid), 64'd0);
        check({tag, "_s1_rvalid"}, 64'(s1_if.rvalid), 64'd0);
        check({tag, "_rgrnt"},     64'(m_rgrnt),      64'd0);
    endtask

    initial begin
        int   rx;
        int   sb;
        logic rr;

        tests = 0;
        fails = 0;
        rst   = 1'b1;

        tbl[0]  = {7'b0100000, 1'b0, 2'b00, 5'b00000};
        tbl[1]  = {7'b0110000, 1'b1, 2'b10, 5'b01000};
        tbl[2]  = {7'b0001001, 1'b0, 2'b10, 5'b00011};
        tbl[3]  = {7'b0001001, 1'b0, 2'b10, 5'b00011};
        tbl[4]  = {7'b0001001, 1'b0, 2'b10, 5'b00011};
        tbl[5]  = {7'b0001101, 1'b0, 2'b10, 5'b00011};
        tbl[6]  = {7'b0000000, 1'b0, 2'b00, 5'b00000};
        tbl[7]  = {7'b1100000, 1'b0, 2'b00, 5'b00000};
        tbl[8]  = {7'b1110000, 1'b1, 2'b01, 5'b10000};
        tbl[9]  = {7'b0101110, 1'b0, 2'b01, 5'b00101};
        tbl[10] = {7'b0100000, 1'b0, 2'b00, 5'b00000};
        tbl[11] = {7'b0110000, 1'b1, 2'b10, 5'b01000};
        tbl[12] = {7'b1101101, 1'b0, 2'b10, 5'b00011};
        tbl[13] = {7'b1100000, 1'b0, 2'b00, 5'b00000};
        tbl[14] = {7'b1110000, 1'b1, 2'b01, 5'b10000};
        tbl[15] = {7'b0001110, 1'b0, 2'b01, 5'b00101};
        tbl[16] = {7'b0000000, 1'b0, 2'b00, 5'b00000};

        s0_if.araddr = S0_ADDR; s0_if.arid = S0_ID; s0_if.arlen = 8'd3;
        s0_if.arsize = 3'd3;    s0_if.arburst = 2'b01; s0_if.arprot = 3'b000;
        s1_if.araddr = S1_ADDR; s1_if.arid = S1_ID; s1_if.arlen = 8'd3;
        s1_if.arsize = 3'd3;    s1_if.arburst = 2'b01; s1_if.arprot = 3'b010;
        quiet_inputs();

        // reset held with random traffic on every input
        for (int c = 0; c < 4; c++) begin
            step();
            s0_if.arvalid = 1'($urandom);
            s1_if.arvalid = 1'($urandom);
            s0_if.rready  = 1'($urandom);
            s1_if.rready  = 1'($urandom);
            m_if.arready  = 1'($urandom);
            m_if.rvalid   = 1'($urandom);
            m_if.rlast    = 1'($urandom);
            m_if.rdata    = {$urandom, $urandom};
            #4;
            check_all_zero("reset");
        end
        quiet_inputs();
        step();
        rst = 1'b0;

        // table: single s1 burst, then contention and fairness
        for (int i = 0; i < NVEC; i++) begin
            step();
            s0_if.arvalid = tbl[i].s0v;
            s1_if.arvalid = tbl[i].s1v;
            m_if.arready  = tbl[i].arrdy;
            m_if.rvalid   = tbl[i].rv;
            m_if.rlast    = tbl[i].rl;
            s0_if.rready  = tbl[i].s0rr;
            s1_if.rready  = tbl[i].s1rr;
            m_if.rdata    = 64'hD000 + 64'(i);
            #4;
            check($sformatf("v%0d_m_arvalid", i),  64'(m_if.arvalid),  64'(tbl[i].mav));
            check($sformatf("v%0d_rgrnt", i),      64'(m_rgrnt),       64'(tbl[i].g));
            check($sformatf("v%0d_s0_arready", i), 64'(s0_if.arready), 64'(tbl[i].s0ar));
            check($sformatf("v%0d_s1_arready", i), 64'(s1_if.arready), 64'(tbl[i].s1ar));
            check($sformatf("v%0d_s0_rvalid", i),  64'(s0_if.rvalid),  64'(tbl[i].s0rv));
            check($sformatf("v%0d_s1_rvalid", i),  64'(s1_if.rvalid),  64'(tbl[i].s1rv));
            check($sformatf("v%0d_m_rready", i),   64'(m_if.rready),   64'(tbl[i].mrr));
            if (tbl[i].mav) begin
                check($sformatf("v%0d_araddr", i), 64'(m_if.araddr), 64'(tbl[i].g[1] ? S1_ADDR : S0_ADDR));
                check($sformatf("v%0d_arid", i),   64'(m_if.arid),   64'(tbl[i].g[1] ? S1_ID : S0_ID));
            end
            if (tbl[i].s1rv) check($sformatf("v%0d_s1_rdata", i), s1_if.rdata, 64'hD000 + 64'(i));
            if (tbl[i].s0rv) check($sformatf("v%0d_s0_rdata", i), s0_if.rdata, 64'hD000 + 64'(i));
        end

        // single-beat read with SLVERR on s1
        step();
        s1_if.arvalid = 1'b1; s1_if.arlen = 8'd0; m_if.arready = 1'b1;
        step();
        #4;
        check("se_m_arvalid", 64'(m_if.arvalid), 64'd1);
        check("se_m_arlen", 64'(m_if.arlen), 64'd0);
        step();
        s1_if.arvalid = 1'b0; m_if.arready = 1'b0;
        m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rresp = RESP_SLVERR;
        m_if.rdata = 64'hBAD0; s1_if.rready = 1'b1;
        #4;
        check("se_s1_rvalid", 64'(s1_if.rvalid), 64'd1);
        check("se_s1_rlast", 64'(s1_if.rlast), 64'd1);
        check("se_s1_rresp", 64'(s1_if.rresp), 64'(RESP_SLVERR));
        check("se_s1_rdata", s1_if.rdata, 64'hBAD0);
        step();
        quiet_inputs();
        #4;
        check("se_idle_rgrnt", 64'(m_rgrnt), 64'd0);
        check("se_idle_s1_rvalid", 64'(s1_if.rvalid), 64'd0);

        // AR backpressure then R backpressure on s0, ARLEN=3
        step();
        s0_if.arvalid = 1'b1; s0_if.arlen = 8'd3;
        for (int k = 0; k < 5; k++) begin
            step();
            #4;
            check($sformatf("bp%0d_m_arvalid", k), 64'(m_if.arvalid), 64'd1);
            check($sformatf("bp%0d_araddr", k), 64'(m_if.araddr), 64'(S0_ADDR));
            check($sformatf("bp%0d_s0_arready", k), 64'(s0_if.arready), 64'd0);
        end
        step();
        m_if.arready = 1'b1;
        #4;
        check("bp_s0_arready_hs", 64'(s0_if.arready), 64'd1);
        rx = 0;
        sb = 0;
        for (int cyc = 0; cyc < 20 && rx < 4; cyc++) begin
            step();
            s0_if.arvalid = 1'b0;
            m_if.arready  = 1'b0;
            rr            = cyc[0];
            m_if.rvalid   = 1'b1;
            m_if.rdata    = 64'hB000 + 64'(sb);
            m_if.rlast    = (sb == 3);
            s0_if.rready  = rr;
            #4;
            check($sformatf("bp_c%0d_m_rready", cyc), 64'(m_if.rready), 64'(rr));
            check($sformatf("bp_c%0d_s0_rvalid", cyc), 64'(s0_if.rvalid), 64'd1);
            if (rr) begin
                check($sformatf("bp_beat%0d_rdata", rx), s0_if.rdata, 64'hB000 + 64'(rx));
                check($sformatf("bp_beat%0d_rlast", rx), 64'(s0_if.rlast), 64'(rx == 3));
                rx++;
            end
            if (m_if.rvalid && m_if.rready) sb++;
        end
        check("bp_beats_received", 64'(rx), 64'd4);
        step();
        quiet_inputs();
        #4;
        check("bp_idle_rgrnt", 64'(m_rgrnt), 64'd0);

        // async reset on beat 2 of an 8-beat s1 burst; prio is 1 beforehand
        step();
        s1_if.arvalid = 1'b1; s1_if.arlen = 8'd7; m_if.arready = 1'b1;
        step();
        step();
        s1_if.arvalid = 1'b0; m_if.arready = 1'b0;
        m_if.rvalid = 1'b1; m_if.rdata = 64'hC000; s1_if.rready = 1'b1;
        #4;
        check("rst_beat1_s1_rvalid", 64'(s1_if.rvalid), 64'd1);
        step();
        m_if.rdata = 64'hC001;
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_s1_rvalid", 64'(s1_if.rvalid), 64'd0);
        check("rst_mid_m_rready", 64'(m_if.rready), 64'd0);
        check("rst_mid_rgrnt", 64'(m_rgrnt), 64'd0);
        check("rst_mid_m_arvalid", 64'(m_if.arvalid), 64'd0);
        quiet_inputs();
        step();
        rst = 1'b0;
        s0_if.arvalid = 1'b1; s1_if.arvalid = 1'b1;
        step();
        #4;
        check("rst_after_rgrnt", 64'(m_rgrnt), 64'b01);
        check("rst_after_araddr", 64'(m_if.araddr), 64'(S0_ADDR));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
